// File: rtl/pll_lock_controller.sv
// PLL bring-up sequencer: SAR search of the VCO coarse band using reference/feedback
// edge counts, then lock declaration and loss-of-lock supervision from PFD pulse widths.
module pll_lock_controller #(
    parameter int BAND_WIDTH    = 4,
    parameter int CAL_WINDOW    = 64,
    parameter int FREQ_TOL      = 1,
    parameter int SETTLE        = 16,
    parameter int PULSE_MAX     = 4,
    parameter int LOCK_COUNT    = 32,
    parameter int TRACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  reference_clk_digital,
    input  logic                  feedback_div_clk_digital,
    input  logic                  output_up_digital,
    input  logic                  output_down_digital,
    output logic                  pll_reset,
    output logic [BAND_WIDTH-1:0] vco_band_code,
    output logic                  cal_done,
    output logic                  cal_fail,
    output logic                  lock_digital,
    output logic [2:0]            state
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_ADJUST  = 3'd3;
    localparam logic [2:0] ST_TRACK   = 3'd4;
    localparam logic [2:0] ST_LOCKED  = 3'd5;
    localparam logic [2:0] ST_FAIL    = 3'd6;

    localparam int FB_MAX = 2 * CAL_WINDOW + 1;
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int REF_W  = $clog2(CAL_WINDOW + 1);
    localparam int FB_W   = $clog2(FB_MAX + 1);
    localparam int DIFF_W = FB_W + 1;
    localparam int PW_W   = $clog2(PULSE_MAX + 2);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int TO_W   = $clog2(TRACK_TIMEOUT + 1);
    localparam int PTR_W  = (BAND_WIDTH > 1) ? $clog2(BAND_WIDTH) : 1;

    localparam logic [SET_W-1:0]         SETTLE_C = SET_W'(SETTLE);
    localparam logic [REF_W-1:0]         REF_C    = REF_W'(CAL_WINDOW);
    localparam logic [FB_W-1:0]          FB_SAT   = FB_W'(FB_MAX);
    localparam logic [PW_W-1:0]          PW_MAX   = PW_W'(PULSE_MAX);
    localparam logic [PW_W-1:0]          PW_SAT   = PW_W'(PULSE_MAX + 1);
    localparam logic [GOOD_W-1:0]        GOOD_C   = GOOD_W'(LOCK_COUNT);
    localparam logic [TO_W-1:0]          TO_C     = TO_W'(TRACK_TIMEOUT);
    localparam logic [PTR_W-1:0]         PTR_MSB  = PTR_W'(BAND_WIDTH - 1);
    localparam logic [BAND_WIDTH-1:0]    CODE_MID = BAND_WIDTH'(1 << (BAND_WIDTH - 1));
    localparam logic signed [DIFF_W-1:0] TOL_P    = DIFF_W'(FREQ_TOL);
    localparam logic signed [DIFF_W-1:0] TOL_N    = DIFF_W'(-FREQ_TOL);

    logic                  ref_prev_reg, fb_prev_reg;
    logic                  ref_rise, fb_rise;
    logic [2:0]            state_reg, state_next;
    logic                  pll_reset_reg, pll_reset_next;
    logic [BAND_WIDTH-1:0] code_reg, code_next, code_tmp;
    logic                  cal_done_reg, cal_done_next;
    logic                  cal_fail_reg, cal_fail_next;
    logic                  lock_reg, lock_next;
    logic [SET_W-1:0]      settle_cnt_reg, settle_cnt_next;
    logic [REF_W-1:0]      ref_cnt_reg, ref_cnt_next;
    logic [FB_W-1:0]       fb_cnt_reg, fb_cnt_next;
    logic [PTR_W-1:0]      ptr_reg, ptr_next;
    logic [PW_W-1:0]       up_w_reg, up_w_next, dn_w_reg, dn_w_next;
    logic                  bad_flag_reg, bad_flag_next;
    logic [GOOD_W-1:0]     good_cnt_reg, good_cnt_next;
    logic [TO_W-1:0]       timeout_reg, timeout_next;
    logic                  miss_reg, miss_next;
    logic signed [DIFF_W-1:0] diff;
    logic                  too_fast, too_slow, period_bad;

    assign ref_rise = reference_clk_digital & ~ref_prev_reg;
    assign fb_rise  = feedback_div_clk_digital & ~fb_prev_reg;

    // Edge history keeps sampling while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_prev_reg <= 1'b0;
            fb_prev_reg  <= 1'b0;
        end else begin
            ref_prev_reg <= reference_clk_digital;
            fb_prev_reg  <= feedback_div_clk_digital;
        end
    end

    assign up_w_next  = !output_up_digital ? '0 : (up_w_reg == PW_SAT) ? up_w_reg : up_w_reg + 1'b1;
    assign dn_w_next  = !output_down_digital ? '0 : (dn_w_reg == PW_SAT) ? dn_w_reg : dn_w_reg + 1'b1;
    assign period_bad = bad_flag_reg | (up_w_next > PW_MAX) | (dn_w_next > PW_MAX);

    assign diff     = $signed({1'b0, fb_cnt_reg}) - $signed({{(DIFF_W - REF_W){1'b0}}, ref_cnt_reg});
    assign too_fast = diff > TOL_P;
    assign too_slow = diff < TOL_N;

    always_comb begin
        state_next      = state_reg;
        pll_reset_next  = pll_reset_reg;
        code_next       = code_reg;
        code_tmp        = code_reg;
        cal_done_next   = cal_done_reg;
        cal_fail_next   = cal_fail_reg;
        lock_next       = lock_reg;
        settle_cnt_next = settle_cnt_reg;
        ref_cnt_next    = ref_cnt_reg;
        fb_cnt_next     = fb_cnt_reg;
        ptr_next        = ptr_reg;
        bad_flag_next   = bad_flag_reg;
        good_cnt_next   = good_cnt_reg;
        timeout_next    = timeout_reg;
        miss_next       = miss_reg;
        case (state_reg)
            ST_IDLE: begin
                pll_reset_next  = 1'b1;
                code_next       = CODE_MID;
                ptr_next        = PTR_MSB;
                cal_done_next   = 1'b0;
                cal_fail_next   = 1'b0;
                lock_next       = 1'b0;
                settle_cnt_next = '0;
                state_next      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (ref_rise) begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                    if (settle_cnt_reg + 1'b1 == SETTLE_C) begin
                        settle_cnt_next = '0;
                        ref_cnt_next    = '0;
                        fb_cnt_next     = '0;
                        state_next      = ST_MEASURE;
                    end
                end
            end
            ST_MEASURE: begin
                if (fb_rise && fb_cnt_reg != FB_SAT)
                    fb_cnt_next = fb_cnt_reg + 1'b1;
                if (ref_rise) begin
                    ref_cnt_next = ref_cnt_reg + 1'b1;
                    if (ref_cnt_reg + 1'b1 == REF_C)
                        state_next = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                if (too_fast)
                    code_tmp[ptr_reg] = 1'b0;
                if ((!too_fast && !too_slow) || ptr_reg == '0) begin
                    code_next      = code_tmp;
                    cal_done_next  = 1'b1;
                    pll_reset_next = 1'b0;
                    good_cnt_next  = '0;
                    timeout_next   = '0;
                    bad_flag_next  = 1'b0;
                    miss_next      = 1'b0;
                    state_next     = ST_TRACK;
                end else begin
                    ptr_next           = ptr_reg - 1'b1;
                    code_tmp[ptr_next] = 1'b1;
                    code_next          = code_tmp;
                    settle_cnt_next    = '0;
                    state_next         = ST_SETTLE;
                end
            end
            ST_TRACK: begin
                bad_flag_next = ref_rise ? 1'b0 : period_bad;
                if (ref_rise) begin
                    timeout_next  = timeout_reg + 1'b1;
                    good_cnt_next = period_bad ? '0 : good_cnt_reg + 1'b1;
                    if (!period_bad && good_cnt_reg + 1'b1 == GOOD_C) begin
                        lock_next  = 1'b1;
                        miss_next  = 1'b0;
                        state_next = ST_LOCKED;
                    end else if (timeout_reg + 1'b1 == TO_C) begin
                        cal_fail_next  = 1'b1;
                        pll_reset_next = 1'b1;
                        state_next     = ST_FAIL;
                    end
                end
            end
            ST_LOCKED: begin
                bad_flag_next = ref_rise ? 1'b0 : period_bad;
                if (ref_rise) begin
                    miss_next = period_bad;
                    // A second consecutive bad period drops lock and restarts the lock hunt.
                    if (period_bad && miss_reg) begin
                        lock_next     = 1'b0;
                        good_cnt_next = '0;
                        timeout_next  = '0;
                        miss_next     = 1'b0;
                        state_next    = ST_TRACK;
                    end
                end
            end
            ST_FAIL: begin
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_reg      <= ST_IDLE;
            pll_reset_reg  <= 1'b1;
            code_reg       <= '0;
            cal_done_reg   <= 1'b0;
            cal_fail_reg   <= 1'b0;
            lock_reg       <= 1'b0;
            settle_cnt_reg <= '0;
            ref_cnt_reg    <= '0;
            fb_cnt_reg     <= '0;
            ptr_reg        <= '0;
            up_w_reg       <= '0;
            dn_w_reg       <= '0;
            bad_flag_reg   <= 1'b0;
            good_cnt_reg   <= '0;
            timeout_reg    <= '0;
            miss_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pll_reset_reg  <= pll_reset_next;
            code_reg       <= code_next;
            cal_done_reg   <= cal_done_next;
            cal_fail_reg   <= cal_fail_next;
            lock_reg       <= lock_next;
            settle_cnt_reg <= settle_cnt_next;
            ref_cnt_reg    <= ref_cnt_next;
            fb_cnt_reg     <= fb_cnt_next;
            ptr_reg        <= ptr_next;
            up_w_reg       <= up_w_next;
            dn_w_reg       <= dn_w_next;
            bad_flag_reg   <= bad_flag_next;
            good_cnt_reg   <= good_cnt_next;
            timeout_reg    <= timeout_next;
            miss_reg       <= miss_next;
        end
    end

    assign pll_reset     = pll_reset_reg;
    assign vco_band_code = code_reg;
    assign cal_done      = cal_done_reg;
    assign cal_fail      = cal_fail_reg;
    assign lock_digital  = lock_reg;
    assign state         = state_reg;
endmodule
